// File: rtl/rob_core_pkg.sv
// rob_core shared constants: entry types, data width, default index width.
// Optional perf counters are enabled by defining ROB_PERF_CNT_EN.
package rob_core_pkg;

  localparam int ROB_BIT_DEF = 5;
  localparam int XLEN        = 32;

  typedef enum logic [1:0] {
    ROB_T_REG    = 2'd0,
    ROB_T_STORE  = 2'd1,
    ROB_T_BRANCH = 2'd2,
    ROB_T_EXIT   = 2'd3
  } rob_type_e;

  function automatic logic [XLEN-1:0] seq_pc(
    input logic [XLEN-1:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/rob_core_lookup.sv
// rob_lookup_port: operand lookup of one ROB entry with
// same-cycle forwarding of a matching CDB broadcast.
module rob_lookup_port
  import rob_core_pkg::*;
#(
  parameter int ROB_BIT = ROB_BIT_DEF
) (
  input  logic [ROB_BIT-1:0] get_i,
  input  logic               busy_i,
  input  logic               rdy_i,
  input  logic [XLEN-1:0]    val_i,
  input  logic               cdb_valid_i,
  input  logic [ROB_BIT-1:0] cdb_entry_i,
  input  logic [XLEN-1:0]    cdb_value_i,
  output logic               ready_o,
  output logic [XLEN-1:0]    value_o
);

  logic fwd;

  // CDB match wins over the stored value; nothing leaks when not ready
  always_comb begin
    fwd     = cdb_valid_i && (cdb_entry_i == get_i);
    ready_o = (busy_i && rdy_i) || fwd;
    value_o = '0;
    if (fwd)
      value_o = cdb_value_i;
    else if (ready_o)
      value_o = val_i;
  end

endmodule

// File: rtl/rob_core.sv
// rob_core: circular reorder buffer, in-order retire, branch flush.
// Define ROB_PERF_CNT_EN to add perf_commits / perf_flushes.
module rob_core
  import rob_core_pkg::*;
#(
  parameter int ROB_BIT = ROB_BIT_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_valid,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic [XLEN-1:0]    issue_pc,
  input  logic               issue_pred_taken,
  input  logic               issue_ready,
  input  logic [XLEN-1:0]    issue_value,
  output logic               rob_full,
  output logic [ROB_BIT-1:0] issue_entry,
  input  logic               cdb_valid,
  input  logic [ROB_BIT-1:0] cdb_entry,
  input  logic [XLEN-1:0]    cdb_value,
  input  logic               cdb_taken,
  input  logic [XLEN-1:0]    cdb_target,
  input  logic [ROB_BIT-1:0] get_rob_entry1,
  input  logic [ROB_BIT-1:0] get_rob_entry2,
  output logic               ready1,
  output logic               ready2,
  output logic [XLEN-1:0]    value1,
  output logic [XLEN-1:0]    value2,
  output logic               rob_commit_reg,
  output logic [4:0]         commit_reg_id,
  output logic [XLEN-1:0]    commit_reg_data,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               commit_store,
  output logic [ROB_BIT-1:0] head_entry,
  output logic               rob_clear_up,
  output logic [XLEN-1:0]    clear_pc,
  output logic               halted
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_commits,
  output logic [31:0]        perf_flushes
`endif
);

  localparam int DEPTH = 1 << ROB_BIT;
  localparam logic [ROB_BIT:0] FULL_CNT = (ROB_BIT+1)'(DEPTH);

  logic [DEPTH-1:0]   busy_q, rdy_q;
  logic [DEPTH-1:0]   pred_q, tk_q;
  rob_type_e          type_q [DEPTH];
  logic [4:0]         rd_q   [DEPTH];
  logic [XLEN-1:0]    pc_q   [DEPTH];
  logic [XLEN-1:0]    val_q  [DEPTH];
  logic [XLEN-1:0]    tgt_q  [DEPTH];

  logic [ROB_BIT-1:0] head_q, head_d;
  logic [ROB_BIT-1:0] tail_q, tail_d;
  logic [ROB_BIT:0]   count_q, count_d;

  logic               creg_q, cst_q, clr_q, halted_q;
  logic [4:0]         cid_q;
  logic [XLEN-1:0]    cdata_q, cpc_q;
  logic [ROB_BIT-1:0] centry_q;

  logic               can_commit, do_flush, do_issue, cdb_hit;
  rob_type_e          head_type;

  assign head_type   = type_q[head_q];
  assign rob_full    = (count_q == FULL_CNT);
  assign issue_entry = tail_q;
  assign head_entry  = head_q;

  // retire/issue decisions and pointer next-state
  always_comb begin
    can_commit = rdy_in && (count_q != '0) && busy_q[head_q]
                 && rdy_q[head_q] && !halted_q;
    do_flush   = can_commit && (head_type == ROB_T_BRANCH)
                 && (tk_q[head_q] != pred_q[head_q]);
    do_issue   = rdy_in && issue_valid && !rob_full && !do_flush;
    cdb_hit    = rdy_in && cdb_valid && busy_q[cdb_entry];
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (do_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (can_commit) head_d = head_q + 1'b1;
      if (do_issue)   tail_d = tail_q + 1'b1;
      count_d = count_q + {{ROB_BIT{1'b0}}, do_issue}
                        - {{ROB_BIT{1'b0}}, can_commit};
    end
  end

  // pointers and per-entry busy/ready state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      rdy_q   <= '0;
    end else if (rdy_in) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (do_flush) begin
        busy_q <= '0;
        rdy_q  <= '0;
      end else begin
        if (can_commit) busy_q[head_q] <= 1'b0;
        if (do_issue) begin
          busy_q[tail_q] <= 1'b1;
          rdy_q[tail_q]  <= issue_ready;
        end
        if (cdb_hit) rdy_q[cdb_entry] <= 1'b1;
      end
    end
  end

  // entry payload; a pre-resolved branch counts as correctly predicted
  always_ff @(posedge clk_in) begin
    if (do_issue) begin
      type_q[tail_q] <= rob_type_e'(issue_type);
      rd_q[tail_q]   <= issue_rd;
      pc_q[tail_q]   <= issue_pc;
      pred_q[tail_q] <= issue_pred_taken;
      tk_q[tail_q]   <= issue_pred_taken;
      val_q[tail_q]  <= issue_value;
      tgt_q[tail_q]  <= '0;
    end
    if (cdb_hit) begin
      val_q[cdb_entry] <= cdb_value;
      tk_q[cdb_entry]  <= cdb_taken;
      tgt_q[cdb_entry] <= cdb_target;
    end
  end

  // registered retire outputs and sticky halt
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      creg_q   <= 1'b0;
      cst_q    <= 1'b0;
      clr_q    <= 1'b0;
      halted_q <= 1'b0;
      cid_q    <= '0;
      cdata_q  <= '0;
      cpc_q    <= '0;
      centry_q <= '0;
    end else if (!rdy_in) begin
      creg_q <= 1'b0;
      cst_q  <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      creg_q <= can_commit && (head_type == ROB_T_REG)
                && (rd_q[head_q] != '0);
      cst_q  <= can_commit && (head_type == ROB_T_STORE);
      clr_q  <= do_flush;
      if (can_commit && head_type == ROB_T_REG) begin
        cid_q    <= rd_q[head_q];
        cdata_q  <= val_q[head_q];
        centry_q <= head_q;
      end
      if (can_commit && head_type == ROB_T_STORE)
        centry_q <= head_q;
      if (do_flush)
        cpc_q <= tk_q[head_q] ? tgt_q[head_q] : seq_pc(pc_q[head_q]);
      if (can_commit && head_type == ROB_T_EXIT)
        halted_q <= 1'b1;
    end
  end

  assign rob_commit_reg   = creg_q;
  assign commit_store     = cst_q;
  assign rob_clear_up     = clr_q;
  assign commit_reg_id    = cid_q;
  assign commit_reg_data  = cdata_q;
  assign commit_rob_entry = centry_q;
  assign clear_pc         = cpc_q;
  assign halted           = halted_q;

  rob_lookup_port #(.ROB_BIT(ROB_BIT)) u_look1 (
    .get_i       (get_rob_entry1),
    .busy_i      (busy_q[get_rob_entry1]),
    .rdy_i       (rdy_q[get_rob_entry1]),
    .val_i       (val_q[get_rob_entry1]),
    .cdb_valid_i (cdb_valid),
    .cdb_entry_i (cdb_entry),
    .cdb_value_i (cdb_value),
    .ready_o     (ready1),
    .value_o     (value1)
  );

  rob_lookup_port #(.ROB_BIT(ROB_BIT)) u_look2 (
    .get_i       (get_rob_entry2),
    .busy_i      (busy_q[get_rob_entry2]),
    .rdy_i       (rdy_q[get_rob_entry2]),
    .val_i       (val_q[get_rob_entry2]),
    .cdb_valid_i (cdb_valid),
    .cdb_entry_i (cdb_entry),
    .cdb_value_i (cdb_value),
    .ready_o     (ready2),
    .value_o     (value2)
  );

`ifdef ROB_PERF_CNT_EN
  logic [31:0] pcom_q, pflu_q;

  // saturating retire and flush counters
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pcom_q <= '0;
      pflu_q <= '0;
    end else begin
      if (can_commit && pcom_q != '1) pcom_q <= pcom_q + 1'b1;
      if (do_flush && pflu_q != '1)   pflu_q <= pflu_q + 1'b1;
    end
  end

  assign perf_commits = pcom_q;
  assign perf_flushes = pflu_q;
`endif

endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: scoreboard bench for rob_core.
// Expected retire events are queued at stimulus time.
module tb_rob_core;

  localparam int RB = 5;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b0;
  logic          rdy_in = 1'b1;
  logic          issue_valid = 1'b0;
  logic [1:0]    issue_type = '0;
  logic [4:0]    issue_rd = '0;
  logic [31:0]   issue_pc = '0;
  logic          issue_pred_taken = 1'b0;
  logic          issue_ready = 1'b0;
  logic [31:0]   issue_value = '0;
  logic          rob_full;
  logic [RB-1:0] issue_entry;
  logic          cdb_valid = 1'b0;
  logic [RB-1:0] cdb_entry = '0;
  logic [31:0]   cdb_value = '0;
  logic          cdb_taken = 1'b0;
  logic [31:0]   cdb_target = '0;
  logic [RB-1:0] get_rob_entry1 = '0;
  logic [RB-1:0] get_rob_entry2 = '0;
  logic          ready1, ready2;
  logic [31:0]   value1, value2;
  logic          rob_commit_reg;
  logic [4:0]    commit_reg_id;
  logic [31:0]   commit_reg_data;
  logic [RB-1:0] commit_rob_entry;
  logic          commit_store;
  logic [RB-1:0] head_entry;
  logic          rob_clear_up;
  logic [31:0]   clear_pc;
  logic          halted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          kind;
    logic [4:0]  id;
    logic [31:0] data;
    logic [4:0]  entry;
  } exp_t;

  exp_t sb[$];

  rob_core #(.ROB_BIT(RB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type),
    .issue_rd(issue_rd), .issue_pc(issue_pc),
    .issue_pred_taken(issue_pred_taken),
    .issue_ready(issue_ready), .issue_value(issue_value),
    .rob_full(rob_full), .issue_entry(issue_entry),
    .cdb_valid(cdb_valid), .cdb_entry(cdb_entry),
    .cdb_value(cdb_value), .cdb_taken(cdb_taken),
    .cdb_target(cdb_target),
    .get_rob_entry1(get_rob_entry1),
    .get_rob_entry2(get_rob_entry2),
    .ready1(ready1), .ready2(ready2),
    .value1(value1), .value2(value2),
    .rob_commit_reg(rob_commit_reg),
    .commit_reg_id(commit_reg_id),
    .commit_reg_data(commit_reg_data),
    .commit_rob_entry(commit_rob_entry),
    .commit_store(commit_store), .head_entry(head_entry),
    .rob_clear_up(rob_clear_up), .clear_pc(clear_pc),
    .halted(halted)
  );

  always #5 clk_in = ~clk_in;

  // kinds: 0 reg write, 1 store release, 2 flush
  always @(negedge clk_in) begin
    if (rst_in && (rob_commit_reg || commit_store || rob_clear_up)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected reg=%0b st=%0b clr=%0b ent=%0d",
                 rob_commit_reg, commit_store, rob_clear_up,
                 commit_rob_entry);
      end else begin
        exp_t e;
        logic ok;
        e = sb.pop_front();
        ok = 1'b1;
        case (e.kind)
          0: ok = rob_commit_reg && !commit_store && !rob_clear_up
                  && commit_reg_id == e.id
                  && commit_reg_data == e.data
                  && commit_rob_entry == e.entry;
          1: ok = commit_store && !rob_commit_reg && !rob_clear_up
                  && commit_rob_entry == e.entry;
          default: ok = rob_clear_up && !rob_commit_reg && !commit_store
                  && clear_pc == e.data;
        endcase
        if (!ok) begin
          errors++;
          $display("FAIL sb_event kind=%0d got reg=%0b st=%0b clr=%0b id=%0d data=%h ent=%0d pc=%h exp id=%0d data=%h ent=%0d",
                   e.kind, rob_commit_reg, commit_store, rob_clear_up,
                   commit_reg_id, commit_reg_data, commit_rob_entry,
                   clear_pc, e.id, e.data, e.entry);
        end
      end
    end
  end

  task automatic push(input int k, input logic [4:0] id,
                      input logic [31:0] d, input logic [4:0] ent);
    exp_t e;
    e.kind = k; e.id = id; e.data = d; e.entry = ent;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd,
                       input logic [31:0] pc, input logic pred,
                       input logic rdy, input logic [31:0] v);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd;
    issue_pc = pc; issue_pred_taken = pred;
    issue_ready = rdy; issue_value = v;
    @(negedge clk_in);
    issue_valid = 1'b0;
  endtask

  task automatic cdb(input logic [4:0] ent, input logic [31:0] v,
                     input logic tk, input logic [31:0] tgt);
    cdb_valid = 1'b1; cdb_entry = ent; cdb_value = v;
    cdb_taken = tk; cdb_target = tgt;
    @(negedge clk_in);
    cdb_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required=0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    #2 rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    #1;
    checks++;
    if ({rob_full, issue_entry, head_entry, rob_commit_reg,
         commit_store, rob_clear_up, halted, ready1, ready2}
        !== '0) begin
      errors++;
      $display("FAIL reset_flags full=%0b ie=%0d he=%0d reg=%0b st=%0b clr=%0b h=%0b r1=%0b r2=%0b required all 0",
               rob_full, issue_entry, head_entry, rob_commit_reg,
               commit_store, rob_clear_up, halted, ready1, ready2);
    end
    checks++;
    if ({commit_reg_id, commit_reg_data, commit_rob_entry,
         clear_pc, value1, value2} !== '0) begin
      errors++;
      $display("FAIL reset_data id=%0d d=%h ent=%0d pc=%h v1=%h v2=%h required 0",
               commit_reg_id, commit_reg_data, commit_rob_entry,
               clear_pc, value1, value2);
    end
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic test_basic();
    issue(2'd0, 5'd5, 32'h0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (issue_entry !== 5'd1) begin
      errors++;
      $display("FAIL basic_tail got=%0d required=1", issue_entry);
    end
    push(0, 5'd5, 32'h1234, 5'd0);
    cdb(5'd0, 32'h1234, 1'b0, 32'h0);
    drain("basic");
    checks++;
    if (head_entry !== 5'd1) begin
      errors++;
      $display("FAIL basic_head got=%0d required=1", head_entry);
    end
  endtask

  task automatic test_lookup_fwd();
    issue(2'd0, 5'd6, 32'h4, 1'b0, 1'b0, 32'h0);
    issue(2'd0, 5'd7, 32'h8, 1'b0, 1'b0, 32'h0);
    issue(2'd0, 5'd8, 32'hc, 1'b0, 1'b0, 32'h0);
    get_rob_entry1 = 5'd3; get_rob_entry2 = 5'd2;
    cdb_valid = 1'b1; cdb_entry = 5'd3; cdb_value = 32'hABCD;
    #1;
    checks++;
    if (ready1 !== 1'b1 || value1 !== 32'hABCD) begin
      errors++;
      $display("FAIL fwd_port1 got=%0b/%h required=1/0000abcd",
               ready1, value1);
    end
    checks++;
    if (ready2 !== 1'b0 || value2 !== 32'h0) begin
      errors++;
      $display("FAIL fwd_port2 got=%0b/%h required=0/00000000",
               ready2, value2);
    end
    @(negedge clk_in);
    cdb_valid = 1'b0;
    #1;
    checks++;
    if (ready1 !== 1'b1 || value1 !== 32'hABCD) begin
      errors++;
      $display("FAIL fwd_stored got=%0b/%h required=1/0000abcd",
               ready1, value1);
    end
    push(0, 5'd6, 32'h11, 5'd1);
    push(0, 5'd7, 32'h22, 5'd2);
    push(0, 5'd8, 32'hABCD, 5'd3);
    cdb(5'd1, 32'h11, 1'b0, 32'h0);
    cdb(5'd2, 32'h22, 1'b0, 32'h0);
    drain("fwd");
    get_rob_entry1 = '0; get_rob_entry2 = '0;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 32; i++)
      issue(2'd0, 5'((i % 31) + 1), 32'(i * 4), 1'b0, 1'b0, 32'h0);
    checks++;
    if (rob_full !== 1'b1 || issue_entry !== 5'd0) begin
      errors++;
      $display("FAIL full_flag got=%0b/%0d required=1/0",
               rob_full, issue_entry);
    end
    issue(2'd0, 5'd20, 32'h999, 1'b0, 1'b1, 32'h77);
    checks++;
    if (rob_full !== 1'b1 || issue_entry !== 5'd0
        || head_entry !== 5'd0) begin
      errors++;
      $display("FAIL full_ignore got=%0b/%0d/%0d required=1/0/0",
               rob_full, issue_entry, head_entry);
    end
    push(0, 5'd1, 32'h500, 5'd0);
    cdb(5'd0, 32'h500, 1'b0, 32'h0);
    push(0, 5'd2, 32'h501, 5'd1);
    cdb(5'd1, 32'h501, 1'b0, 32'h0);
    issue(2'd0, 5'd9, 32'h600, 1'b0, 1'b1, 32'h600);
    checks++;
    if (rob_full !== 1'b0 || issue_entry !== 5'd1
        || head_entry !== 5'd2) begin
      errors++;
      $display("FAIL full_wrap got=%0b/%0d/%0d required=0/1/2",
               rob_full, issue_entry, head_entry);
    end
    drain("full");
    do_reset();
  endtask

  task automatic test_branch_flush();
    issue(2'd2, 5'd0, 32'h100, 1'b0, 1'b0, 32'h0);
    issue(2'd0, 5'd3, 32'h104, 1'b0, 1'b1, 32'h77);
    issue(2'd0, 5'd4, 32'h108, 1'b0, 1'b0, 32'h0);
    push(2, 5'd0, 32'h200, 5'd0);
    cdb(5'd0, 32'h0, 1'b1, 32'h200);
    issue(2'd0, 5'd11, 32'h10c, 1'b0, 1'b1, 32'h5);
    get_rob_entry1 = 5'd1;
    #1;
    checks++;
    if (head_entry !== 5'd0 || issue_entry !== 5'd0
        || rob_full !== 1'b0 || ready1 !== 1'b0) begin
      errors++;
      $display("FAIL flush_state got he=%0d ie=%0d full=%0b r1=%0b required 0/0/0/0",
               head_entry, issue_entry, rob_full, ready1);
    end
    repeat (3) @(negedge clk_in);
    drain("flush1");
    issue(2'd2, 5'd0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0);
    push(2, 5'd0, 32'h0, 5'd0);
    cdb(5'd0, 32'h0, 1'b0, 32'h1234);
    drain("flush_wrap");
    issue(2'd2, 5'd0, 32'h40, 1'b1, 1'b0, 32'h0);
    cdb(5'd0, 32'h0, 1'b1, 32'h80);
    repeat (2) @(negedge clk_in);
    checks++;
    if (head_entry !== 5'd1 || rob_clear_up !== 1'b0) begin
      errors++;
      $display("FAIL branch_ok got he=%0d clr=%0b required=1/0",
               head_entry, rob_clear_up);
    end
    get_rob_entry1 = '0;
    do_reset();
  endtask

  task automatic test_rd0_exit();
    issue(2'd0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h5);
    repeat (3) @(negedge clk_in);
    checks++;
    if (head_entry !== 5'd1) begin
      errors++;
      $display("FAIL rd0_head got=%0d required=1", head_entry);
    end
    issue(2'd1, 5'd0, 32'h4, 1'b0, 1'b0, 32'h0);
    push(1, 5'd0, 32'h0, 5'd1);
    cdb(5'd1, 32'h0, 1'b0, 32'h0);
    drain("store");
    issue(2'd3, 5'd0, 32'h8, 1'b0, 1'b1, 32'h0);
    issue(2'd0, 5'd10, 32'hc, 1'b0, 1'b1, 32'h10);
    repeat (4) @(negedge clk_in);
    checks++;
    if (halted !== 1'b1 || head_entry !== 5'd3
        || issue_entry !== 5'd4) begin
      errors++;
      $display("FAIL exit_halt got h=%0b he=%0d ie=%0d required=1/3/4",
               halted, head_entry, issue_entry);
    end
    repeat (2) @(negedge clk_in);
    checks++;
    if (halted !== 1'b1 || head_entry !== 5'd3) begin
      errors++;
      $display("FAIL exit_sticky got h=%0b he=%0d required=1/3",
               halted, head_entry);
    end
    do_reset();
  endtask

  task automatic test_rdy_low();
    issue(2'd0, 5'd12, 32'h0, 1'b0, 1'b1, 32'h99);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checks++;
      if (head_entry !== 5'd0 || rob_commit_reg !== 1'b0
          || issue_entry !== 5'd1) begin
        errors++;
        $display("FAIL rdy_hold cyc=%0d got he=%0d reg=%0b ie=%0d required 0/0/1",
                 i, head_entry, rob_commit_reg, issue_entry);
      end
    end
    push(0, 5'd12, 32'h99, 5'd0);
    rdy_in = 1'b1;
    drain("rdy");
  endtask

  task automatic test_async_reset();
    do_reset();
    push(0, 5'd13, 32'hAA, 5'd0);
    issue(2'd0, 5'd13, 32'h0, 1'b0, 1'b1, 32'hAA);
    issue(2'd0, 5'd14, 32'h4, 1'b0, 1'b1, 32'hBB);
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if ({rob_commit_reg, commit_reg_id, commit_reg_data,
         head_entry, issue_entry, rob_full, halted} !== '0) begin
      errors++;
      $display("FAIL async_rst got reg=%0b id=%0d d=%h he=%0d ie=%0d full=%0b h=%0b required 0",
               rob_commit_reg, commit_reg_id, commit_reg_data,
               head_entry, issue_entry, rob_full, halted);
    end
    @(negedge clk_in);
    rst_in = 1'b1;
    drain("async");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lookup_fwd();
    test_full();
    test_branch_flush();
    test_rd0_exit();
    test_rdy_low();
    test_async_reset();
    repeat (3) @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
